comparador_seq: RTL
===================

// Module: comparador_seq
// PURPOSE
//  Parametrised, multi-cycle unsigned comparator that reports A==B, A<B and A>B.
//  Scans operands MSB-first, DIGIT bits per cycle, trading latency for a small
//  per-digit comparator. Sits between the datapath registers and the control
//  FSMs that need wide equality/magnitude results. Uses a start/busy/done handshake.
// PARAMETERS
//  WIDTH  16  operand width in bits; must be a multiple of DIGIT
//  DIGIT   4  bits compared per clock cycle; 1 <= DIGIT <= WIDTH
//  NDIG   WIDTH/DIGIT  localparam: number of digit steps
// PORTS
//  clk    in   1      single clock, rising edge
//  rst    in   1      asynchronous reset, active-high
//  start  in   1      request a compare; honoured only when busy=0
//  A      in   WIDTH  operand A, sampled on the accepted start edge only
//  B      in   WIDTH  operand B, sampled on the accepted start edge only
//  busy   out  1      high while a compare is in progress
//  done   out  1      one-cycle pulse when EQ/LT/GT become valid
//  EQ     out  1      A == B (valid from done; held until the next accepted start)
//  LT     out  1      A <  B (unsigned)
//  GT     out  1      A >  B (unsigned)
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; busy=done=EQ=LT=GT=0; internal shift regs and counter cleared.
//  - FSM: IDLE -start-> RUN -last digit (or decided, see CONFIGURATION)-> DONE -> IDLE.
//  - IDLE: on start=1, capture A,B into shift regs, counter=0, clear EQ/LT/GT, busy=1 next cycle.
//  - RUN: each cycle compare the top DIGIT bits of both shift regs, then shift left by DIGIT and increment counter.
//    The first differing digit latches LT or GT. Later digits never overwrite a latched decision.
//  - Leaving RUN after step NDIG-1: if no difference was found, EQ=1. Exactly one of EQ/LT/GT is 1.
//  - DONE: done=1 for exactly one cycle, busy=0. Results are registered and stay stable until the next accepted start.
//  - Latency: done asserts NDIG+1 cycles after the start edge. WIDTH==DIGIT gives 2 cycles.
//  - start while busy=1 is ignored; it is neither queued nor counted. start in the DONE cycle is accepted (busy=0).
//  - A/B changes after capture have no effect on the compare in flight.
//  - Counter is $clog2(NDIG+1) bits wide and never wraps within one compare.
//  - rst mid-RUN: abort immediately. No done pulse, outputs 0, state IDLE.
//  - Results are 0 during busy; a consumer samples them only on done or while idle.
// CONFIGURATION
//  `CMP_EARLY_EXIT_EN defined: RUN exits to DONE in the cycle after the first
//    differing digit is examined. Latency ranges from 2 (MSB digit differs) to NDIG+1.
//  Not defined: fixed latency NDIG+1 regardless of operands (constant-time compare).
//  EQ always needs all NDIG steps in both modes.
// STRUCTURE
//  Package comparador_pkg: typedef enum logic [1:0] {IDLE, RUN, DONE} cmp_state_t;
//    typedef struct packed {logic eq, lt, gt;} cmp_res_t; parameter check helpers.
//  Sub-module comparador_digito (combinational, parameter DIGIT): inputs a,b[DIGIT-1:0];
//    outputs eq (per-bit XNOR reduced with AND) and lt (unsigned a<b).
//    Instantiated once in comparador_seq.
//  Elaboration-time assertion: WIDTH % DIGIT == 0.
// TESTING  (WIDTH=16, DIGIT=4 unless stated; run both macro settings)
//  1 Assert rst, then release -> busy=done=EQ=LT=GT=0; no done pulse with start held low.
//  2 A=B=16'hA5A5, start 1 cycle -> done 5 cycles later, EQ=1 LT=0 GT=0 (both modes).
//  3 A=16'h1234, B=16'h1235 -> LT=1 with done at +5 in both modes (difference is in the last digit).
//  4 A=16'h8000, B=16'h7FFF -> GT=1; done at +2 with EARLY_EXIT_EN, at +5 without.
//  5 start held high through the compare with A/B changing every cycle -> the first
//    values win, one done only; the next start (in the DONE cycle) is accepted with current A/B.
//  6 rst pulsed on the 2nd RUN cycle -> outputs 0 at once, no done, a new compare works;
//    also WIDTH=8, DIGIT=8 with A=8'h01, B=8'h00 -> GT=1 at +2.

Source files
------------

// File: rtl/comparador_pkg.sv
// Shared types and elaboration helpers for the sequential digit-serial comparator.
package comparador_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} cmp_state_t;

  typedef struct packed {
    logic eq;
    logic lt;
    logic gt;
  } cmp_res_t;

  // Legal geometry: DIGIT in [1, WIDTH] and WIDTH an exact multiple of DIGIT.
  function automatic bit cfg_ok(int width, int digit);
    return (digit >= 1) && (digit <= width) && ((width % digit) == 0);
  endfunction

  function automatic int num_digits(int width, int digit);
    return width / digit;
  endfunction

endpackage

// File: rtl/comparador_digito.sv
// Combinational single-digit unsigned comparator: equality and a<b.
module comparador_digito #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  output logic             eq,
  output logic             lt
);

  assign eq = &(a ~^ b);
  assign lt = (a < b);

endmodule

// File: rtl/comparador_seq.sv
// Multi-cycle unsigned comparator, MSB-first, DIGIT bits per clock.
// Optional macro CMP_EARLY_EXIT_EN: leave RUN right after the first differing digit.
//
//  state | meaning
//  IDLE  | waiting for start; results from the last compare held
//  RUN   | one digit compared per cycle, operands shifted left
//  DONE  | one-cycle done pulse; start here is accepted
module comparador_seq
  import comparador_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             EQ,
  output logic             LT,
  output logic             GT
);

  localparam int NDIG = num_digits(WIDTH, DIGIT);
  localparam int CW   = $clog2(NDIG + 1);
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  if (!cfg_ok(WIDTH, DIGIT)) begin : g_cfg_err
    $error("comparador_seq: WIDTH must be a nonzero multiple of DIGIT");
  end

  cmp_state_t       state_q, state_d;
  logic [WIDTH-1:0] sha_q, shb_q;
  logic [WIDTH-1:0] sha_nx, shb_nx;
  logic [CW-1:0]    cnt_q;
  logic             dlt_q, dgt_q;
  cmp_res_t         res_q;

  logic dig_eq, dig_lt;
  logic new_lt, new_gt;
  logic accept, finish, early;

  comparador_digito #(.DIGIT(DIGIT)) u_digito (
    .a  (sha_q[WIDTH-1 -: DIGIT]),
    .b  (shb_q[WIDTH-1 -: DIGIT]),
    .eq (dig_eq),
    .lt (dig_lt)
  );

  // A single-digit operand has nothing left to shift in after its only step.
  if (NDIG > 1) begin : g_shift
    assign sha_nx = {sha_q[WIDTH-DIGIT-1:0], {DIGIT{1'b0}}};
    assign shb_nx = {shb_q[WIDTH-DIGIT-1:0], {DIGIT{1'b0}}};
  end else begin : g_noshift
    assign sha_nx = '0;
    assign shb_nx = '0;
  end

  // A decision latched on an earlier digit masks everything below it.
  assign new_lt = dlt_q | (~(dlt_q | dgt_q) & dig_lt);
  assign new_gt = dgt_q | (~(dlt_q | dgt_q) & ~dig_eq & ~dig_lt);

`ifdef CMP_EARLY_EXIT_EN
  assign early = ~dig_eq;
`else
  assign early = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if ((cnt_q == LAST) || early) begin
          finish  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sha_q <= '0;
      shb_q <= '0;
      cnt_q <= '0;
      dlt_q <= 1'b0;
      dgt_q <= 1'b0;
      res_q <= '0;
    end else if (accept) begin
      sha_q <= A;
      shb_q <= B;
      cnt_q <= '0;
      dlt_q <= 1'b0;
      dgt_q <= 1'b0;
      res_q <= '0;
    end else if (state_q == RUN) begin
      sha_q <= sha_nx;
      shb_q <= shb_nx;
      cnt_q <= cnt_q + 1'b1;
      dlt_q <= new_lt;
      dgt_q <= new_gt;
      if (finish) begin
        res_q.eq <= ~(new_lt | new_gt);
        res_q.lt <= new_lt;
        res_q.gt <= new_gt;
      end
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign EQ   = res_q.eq;
  assign LT   = res_q.lt;
  assign GT   = res_q.gt;

endmodule
